// File: rtl/change_dispenser.sv
// Vend-then-pay-change stage with a one-deep pending request buffer.
// Optional ejector-ack watchdog enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic [2:0] r,
    input  logic       eject_ack,
    output logic       vend,
    output logic       eject_two,
    output logic       eject_one,
    output logic       done,
    output logic       busy,
    output logic       overrun,
    output logic       fault
);

    localparam int unsigned REM_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_EJ2,
        S_EJ1,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [REM_W-1:0] rem, rem_nxt, rem_m1, rem_m2;
    logic [REM_W-1:0] pend_r, pend_r_nxt;
    logic             pend_v, pend_v_nxt;
    logic             overrun_nxt;
    logic             unload;
    logic             timeout_c;

    // Pick the next coin (or finish) for a given remaining amount.
    function automatic state_t sel(input logic [REM_W-1:0] x);
        if (x >= REM_W'(2))      return S_EJ2;
        else if (x == REM_W'(1)) return S_EJ1;
        else                     return S_DONE;
    endfunction

    assign rem_m1 = rem - REM_W'(1);
    assign rem_m2 = rem - REM_W'(2);

`ifdef CHANGE_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_c = ((wait_cnt + CNT_W'(1)) >= CNT_W'(TIMEOUT_CYCLES));

    // Counts unacknowledged cycles of the current coin request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state == S_EJ2) || (state == S_EJ1)) begin
            if (eject_ack) wait_cnt <= '0;
            else           wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_c          = 1'b0;
    assign unused_timeout_cfg = ^CNT_W'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        pend_v_nxt  = pend_v;
        pend_r_nxt  = pend_r;
        overrun_nxt = overrun;
        unload      = 1'b0;

        case (state)
            S_IDLE: begin
                if (d) begin
                    state_nxt = S_VEND;
                    rem_nxt   = r;
                end
            end
            S_VEND:  state_nxt = sel(rem);
            S_EJ2: begin
                if (eject_ack) begin
                    rem_nxt   = rem_m2;
                    state_nxt = sel(rem_m2);
                end else if (timeout_c) begin
                    state_nxt = S_FAULT;
                end
            end
            S_EJ1: begin
                if (eject_ack) begin
                    rem_nxt   = rem_m1;
                    state_nxt = sel(rem_m1);
                end else if (timeout_c) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DONE: begin
                if (pend_v) begin
                    state_nxt  = S_VEND;
                    rem_nxt    = pend_r;
                    pend_v_nxt = 1'b0;
                    unload     = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase

        // A request arriving while busy is buffered; an unload frees the slot this cycle.
        if (d && (state != S_IDLE)) begin
            if (!pend_v || unload) begin
                pend_v_nxt = 1'b1;
                pend_r_nxt = r;
            end else begin
                overrun_nxt = 1'b1;
            end
        end
    end

    // State, datapath and registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rem       <= '0;
            pend_v    <= 1'b0;
            pend_r    <= '0;
            overrun   <= 1'b0;
            vend      <= 1'b0;
            eject_two <= 1'b0;
            eject_one <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            pend_v    <= pend_v_nxt;
            pend_r    <= pend_r_nxt;
            overrun   <= overrun_nxt;
            vend      <= (state_nxt == S_VEND);
            eject_two <= (state_nxt == S_EJ2);
            eject_one <= (state_nxt == S_EJ1);
            done      <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_IDLE);
`ifdef CHANGE_TIMEOUT_EN
            fault     <= (state_nxt == S_FAULT);
`else
            fault     <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a coin-queue reference model.
module tb_change_dispenser;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       d;
    logic [2:0] r;
    logic       eject_ack;
    logic       vend, eject_two, eject_one, done, busy, overrun, fault;
    logic [6:0] dut_outs;

    int checks = 0;
    int errors = 0;

    // Reference model: a sale is a queue of coin values walked through phases.
    bit m_busy, m_ovr, m_fault, m_pv;
    int m_phase;      // 0 vend, 1 paying, 2 done, 3 faulted
    int m_coins[$];
    int m_pr, m_wait, m_paid;

    int dut_paid, ej2_cycles, ej1_cycles;

    change_dispenser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .d(d), .r(r), .eject_ack(eject_ack),
        .vend(vend), .eject_two(eject_two), .eject_one(eject_one),
        .done(done), .busy(busy), .overrun(overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    assign dut_outs = {vend, eject_two, eject_one, done, busy, overrun, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] model_outs();
        logic cv, c2, c1, cd;
        cv = m_busy && (m_phase == 0);
        c2 = m_busy && (m_phase == 1) && (m_coins[0] == 2);
        c1 = m_busy && (m_phase == 1) && (m_coins[0] == 1);
        cd = m_busy && (m_phase == 2);
        return {cv, c2, c1, cd, m_busy, m_ovr, m_fault};
    endfunction

    task automatic model_start(input int amt);
        m_coins.delete();
        for (int i = 0; i < amt / 2; i++) m_coins.push_back(2);
        if (amt % 2 == 1) m_coins.push_back(1);
        m_busy  = 1'b1;
        m_phase = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_ovr = 0; m_fault = 0; m_pv = 0;
        m_phase = 0; m_pr = 0; m_wait = 0;
        m_coins.delete();
    endtask

    task automatic model_step(input bit di, input int ri, input bit ai);
        bit was_busy, unl;
        was_busy = m_busy;
        unl = 0;
        if (!m_busy) begin
            if (di) model_start(ri);
        end else begin
            case (m_phase)
                0: begin
                    m_phase = (m_coins.size() > 0) ? 1 : 2;
                    m_wait  = 0;
                end
                1: begin
                    if (ai) begin
                        m_paid += m_coins[0];
                        void'(m_coins.pop_front());
                        m_wait = 0;
                        if (m_coins.size() == 0) m_phase = 2;
                    end else begin
`ifdef CHANGE_TIMEOUT_EN
                        m_wait++;
                        if (m_wait >= TO) begin
                            m_phase = 3;
                            m_fault = 1;
                        end
`endif
                    end
                end
                2: begin
                    if (m_pv) begin
                        model_start(m_pr);
                        m_pv = 0;
                        unl  = 1;
                    end else begin
                        m_busy = 0;
                    end
                end
                default: ;
            endcase
            if (di) begin
                if (!m_pv || unl) begin
                    m_pv = 1;
                    m_pr = ri;
                end else begin
                    m_ovr = 1;
                end
            end
        end
        if (!was_busy && !di) m_wait = 0;
    endtask

    // One clock: compare outputs, drive new inputs, advance the model.
    task automatic cycle(input bit di, input int ri, input bit ai);
        @(negedge clk);
        check("outs", 32'(dut_outs), 32'(model_outs()));
        check("excl", 32'(eject_two & eject_one), 32'd0);
        if (eject_two) ej2_cycles++;
        if (eject_one) ej1_cycles++;
        if (eject_two && ai) dut_paid += 2;
        if (eject_one && ai) dut_paid += 1;
        d = di;
        r = 3'(ri);
        eject_ack = ai;
        model_step(di, ri, ai);
    endtask

    task automatic do_reset();
        @(negedge clk);
        d = 0; r = 0; eject_ack = 0;
        reset = 1'b0;
        #1;
        check("rst_outs", 32'(dut_outs), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_counts();
        dut_paid = 0; ej2_cycles = 0; ej1_cycles = 0;
    endtask

    initial begin
        reset = 1'b0; d = 0; r = 0; eject_ack = 0;
        model_reset();
        m_paid = 0;
        clear_counts();
        @(negedge clk);
        check("por_outs", 32'(dut_outs), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // r=0: vend then done, no coins
        cycle(1, 0, 1);
        repeat (4) cycle(0, 0, 1);
        check("r0_paid", 32'(dut_paid), 32'd0);

        // r=7 with ack high: three twos, one one
        clear_counts();
        cycle(1, 7, 1);
        repeat (8) cycle(0, 0, 1);
        check("r7_paid", 32'(dut_paid), 32'd7);
        check("r7_ej2", 32'(ej2_cycles), 32'd3);
        check("r7_ej1", 32'(ej1_cycles), 32'd1);

        // r=2 with ack delayed 4 cycles
        clear_counts();
        cycle(1, 2, 0);
        cycle(0, 0, 0);
        repeat (4) cycle(0, 0, 0);
        cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 0);
        check("slow_ej2", 32'(ej2_cycles), 32'd5);
        check("slow_paid", 32'(dut_paid), 32'd2);

        // three back-to-back requests: one runs, one queued, one dropped
        clear_counts();
        cycle(1, 3, 1);
        cycle(1, 1, 1);
        cycle(1, 5, 1);
        repeat (10) cycle(0, 0, 1);
        check("b2b_paid", 32'(dut_paid), 32'd4);
        check("b2b_ovr", 32'(overrun), 32'd1);
        check("b2b_idle", 32'(busy), 32'd0);

        // reset in the middle of paying r=6
        do_reset();
        cycle(1, 6, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("mid_ej2", 32'(eject_two), 32'd1);
        do_reset();
        clear_counts();
        cycle(1, 1, 1);
        repeat (5) cycle(0, 0, 1);
        check("post_rst_ej1", 32'(ej1_cycles), 32'd1);
        check("post_rst_paid", 32'(dut_paid), 32'd1);

        // ejector never acknowledges
        clear_counts();
        cycle(1, 1, 0);
`ifdef CHANGE_TIMEOUT_EN
        repeat (12) cycle(0, 0, 0);
        check("to_fault", 32'(fault), 32'd1);
        check("to_ej1", 32'(ej1_cycles), 32'd4);
`else
        cycle(0, 0, 0);
        repeat (50) cycle(0, 0, 0);
        check("hang_ej1", 32'(ej1_cycles), 32'd50);
        check("hang_fault", 32'(fault), 32'd0);
`endif
        do_reset();

        // randomized traffic
        m_paid = 0;
        clear_counts();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 9) < 3), int'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) < 6));
            end
        end
        cycle(0, 0, 0);
        check("rand_paid", 32'(dut_paid), 32'(m_paid));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine controller. Consumes the one-cycle dispense pulse `d` and the 3-bit change amount `r`. Releases the product, then pays the change out one coin at a time through a handshake with the coin ejector. Holds one pending request so back-to-back sales are not lost.

## Interface
- `TIMEOUT_CYCLES`, default 15: cycles to wait for `eject_ack` before faulting. Used only when `CHANGE_TIMEOUT_EN` is defined. Legal range 1–255.
- `clk` input, 1: system clock. All state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `d` input, 1: dispense pulse from the vending machine.
- `r` input, 3: change owed in units. Sampled in the same cycle as `d=1`.
- `eject_ack` input, 1: ejector accepted the currently requested coin.
- `vend` output, 1: product release, one cycle per sale.
- `eject_two` output, 1: request one 2-unit coin. Held until acknowledged.
- `eject_one` output, 1: request one 1-unit coin. Held until acknowledged.
- `done` output, 1: one-cycle pulse when a sale's change is fully paid.
- `busy` output, 1: high when state ≠ IDLE.
- `overrun` output, 1: sticky; a request was dropped.
- `fault` output, 1: sticky; ejector timeout.

## Operation
- States: IDLE, VEND, EJ2, EJ1, DONE, FAULT.
- Outputs are Moore decodes of the state:
  - `vend`=VEND, `eject_two`=EJ2, `eject_one`=EJ1, `done`=DONE, `fault`=FAULT.
  - `busy` = state≠IDLE.
- `eject_two` and `eject_one` are never high together.
- Registers:
  - `rem[2:0]`: change remaining for the current sale.
  - `pend_v` and `pend_r[2:0]`: the one-deep pending buffer.
- Coin selection rule SEL(x):
  - x≥2 → EJ2
  - x=1 → EJ1
  - x=0 → DONE
- IDLE:
  - `d=1` → VEND, `rem<=r`.
- VEND:
  - → SEL(`rem`) unconditionally.
- EJ2:
  - `eject_ack=1` → `rem<=rem-2`, next state SEL(`rem-2`).
  - `eject_ack=0` → stay; `rem` unchanged.
- EJ1:
  - `eject_ack=1` → `rem<=rem-1`, next state SEL(`rem-1`).
  - `eject_ack=0` → stay; `rem` unchanged.
- `eject_ack` is ignored in all states other than EJ2 and EJ1.
- DONE:
  - `pend_v=1` → VEND, `rem<=pend_r`, `pend_v<=0`.
  - Otherwise → IDLE.
- Capture while busy:
  - `d=1` in any state other than IDLE, with `pend_v=0` → `pend_v<=1`, `pend_r<=r`.
  - If DONE unloads the buffer in the same cycle as a capture, the unload takes the old `pend_r` and the new request occupies the buffer (`pend_v` stays 1).
- Overrun:
  - `d=1` while busy, `pend_v=1`, and no unload this cycle → request dropped, `overrun<=1`.
  - Cleared only by reset.
- Arithmetic:
  - `rem` is 3-bit unsigned and never underflows, because SEL guards each subtraction.
  - Coins ejected per sale: floor(r/2) two-unit coins, then (r mod 2) one-unit coins.
- Reset asserted at any time, including mid-ejection:
  - Immediately: state=IDLE, `rem`=0, `pend_v`=0, `pend_r`=0, timeout counter=0.
  - All outputs 0.
  - A partially paid sale is abandoned.

## Timing
- Sale with `d=1` sampled at edge N:
  - `vend` high during cycle N+1.
  - First eject request (or `done` if `r`=0) during cycle N+2.
- Each coin with `eject_ack` already high takes 1 cycle.
- Each coin with acknowledge delayed k cycles takes k+1 cycles.
- Latency from `d` to `done` with `eject_ack` tied high is 2 + ceil(r/2) cycles. Example: `r`=3 gives VEND, EJ2, EJ1, DONE.
- A queued sale starts its VEND one cycle after DONE, with no IDLE cycle in between.
- `d` is a single-cycle pulse. `d` held high for several cycles counts as one request per cycle.

## Configuration
- `CHANGE_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to EJ2/EJ1 and on every accepted ack.
  - It increments each cycle in EJ2/EJ1 while `eject_ack=0`.
  - On reaching `TIMEOUT_CYCLES`, next state is FAULT.
  - FAULT: `fault`=1, `busy`=1, no coin requests, and new `d` is handled by the pending/overrun rules.
  - FAULT is exited only by reset.
- Not defined:
  - No counter and FAULT is unreachable.
  - `fault` is tied to 0.
  - EJ2/EJ1 wait indefinitely for `eject_ack`.

## Test plan
- Reset mid-EJ2 with `r`=6 → all outputs 0 immediately; a new `d` with `r`=1 after release completes normally: one `eject_one`, then `done`.
- `d`, `r`=0, ack high → `vend` at N+1, `done` at N+2, no eject; `busy` low at N+3.
- `d`, `r`=7, ack high → `eject_two` for 3 cycles, then `eject_one` for 1 cycle, then `done`; total paid = 7.
- `r`=2, ack held low 4 cycles then high → `eject_two` high for 5 cycles, then `done`; exactly one coin counted.
- Three `d` pulses on consecutive cycles (`r`=3, 1, 5) → the first sale pays 3; the second is buffered and its VEND follows DONE directly and pays 1; the third is dropped and `overrun`=1.
- With `CHANGE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `r`=1, ack never → FAULT entered 4 cycles after EJ1 entry with `fault`=1. Without the macro: `eject_one` stays high for 50 cycles and `fault`=0.
